// File: rtl/prog_loader_pkg.sv
// Shared FSM encoding and frame constants for the program-memory loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and keeps the
// running XOR checksum of every payload byte.
module prog_loader_word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        lane_d     = lane_q;
        buf_d      = buf_q;
        csum_d     = csum_q;
        word_valid = 1'b0;
        if (clear) begin
            lane_d = '0;
            buf_d  = '0;
            csum_d = '0;
        end else if (byte_en) begin
            buf_d[{lane_q, 3'b000} +: 8] = byte_in;
            csum_d     = csum_q ^ byte_in;
            lane_d     = lane_q + 2'd1;
            word_valid = (lane_q == 2'(WORD_BYTES - 1));
        end
    end

    // word includes the byte being accepted this cycle, so the top can
    // capture the complete word on the same edge as the 4th handshake.
    assign word = buf_d;
    assign csum = csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            buf_q  <= '0;
            csum_q <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
            csum_q <= csum_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (length, payload words, XOR checksum) into the
// instruction BRAM and holds the core in reset until a clean load completes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WORDS  = 4096
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           ram_in,
    output logic [3:0]            byte_w_en,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output state_e                dbg_state
);

    localparam logic [ADDR_WIDTH:0] WCNT_ONE = 1;

    // Handshake: a byte transfers on a rising edge when in_valid && in_ready.
    // in_ready is registered and depends only on the FSM state.
    state_e                  state_q, state_d;
    logic [31:0]             len_q, len_d;
    logic [1:0]              len_cnt_q, len_cnt_d;
    logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]             ram_in_q, ram_in_d;
    logic [3:0]              bwe_q, bwe_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic        accept;
    logic        asm_clear, asm_en, asm_word_valid;
    logic [31:0] asm_word;
    logic [7:0]  asm_csum;
    logic [31:0] len_next;

    assign accept   = in_valid && in_ready_q;
    assign len_next = {in_data, len_q[31:8]};

    prog_loader_word_assembler u_asm (
        .clk        (sysclk),
        .rst_n      (rst),
        .clear      (asm_clear),
        .byte_en    (asm_en),
        .byte_in    (in_data),
        .word_valid (asm_word_valid),
        .word       (asm_word),
        .csum       (asm_csum)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        len_cnt_d  = len_cnt_q;
        word_cnt_d = word_cnt_q;
        wr_addr_d  = wr_addr_q;
        ram_in_d   = ram_in_q;
        bwe_d      = 4'h0;
        asm_clear  = 1'b0;
        asm_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    len_d      = '0;
                    len_cnt_d  = '0;
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d     = len_next;
                    len_cnt_d = len_cnt_q + 2'd1;
                    if (len_cnt_q == 2'(LEN_BYTES - 1)) begin
                        if (len_next > 32'(MAX_WORDS)) state_d = ST_ERR;
                        else if (len_next == 32'd0)   state_d = ST_CSUM;
                        else                           state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    asm_en = 1'b1;
                    if (asm_word_valid) begin
                        wr_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        ram_in_d   = asm_word;
                        bwe_d      = 4'hF;
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                        // Length fits in ADDR_WIDTH+1 bits after the MAX_WORDS check.
                        if (word_cnt_d == len_q[ADDR_WIDTH:0]) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) state_d = (in_data == asm_csum) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
        cpu_hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            len_cnt_q  <= '0;
            word_cnt_q <= '0;
            in_ready_q <= 1'b0;
            wr_addr_q  <= '0;
            ram_in_q   <= '0;
            bwe_q      <= 4'h0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            len_cnt_q  <= len_cnt_d;
            word_cnt_q <= word_cnt_d;
            in_ready_q <= in_ready_d;
            wr_addr_q  <= wr_addr_d;
            ram_in_q   <= ram_in_d;
            bwe_q      <= bwe_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_addr   = wr_addr_q;
    assign ram_in    = ram_in_q;
    assign byte_w_en = bwe_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule
